// File: rtl/shiftreg_ser.sv
// Parallel-to-serial shift register with valid/ready word intake, gapless back-to-back words,
// loop (continuous rotation) mode and abort. All outputs except o_rdy are registered.
module shiftreg_ser #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter int CNT_W      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic             i_loop,
  input  logic             i_shift_en,
  input  logic             i_abort,
  output logic             o_out,
  output logic             o_out_vld,
  output logic             o_last,
  output logic             o_busy
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             loop_q, loop_d;
  logic             out_q, out_d;
  logic             out_vld_q, out_vld_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             accept_s;

  // Bit k of the serial sequence, honouring the configured bit order.
  function automatic logic bit_at(input logic [WIDTH-1:0] w, input logic [CNT_W-1:0] k);
    logic [CNT_W-1:0] idx;
    idx = MSB_FIRST ? (CNT_LAST - k) : k;
    return w[idx];
  endfunction

  // Ready is combinational so a new word can be taken on the very cycle the last bit advances.
  assign o_rdy = !rst && !i_abort &&
                 ((state_q == S_IDLE) || ((state_q == S_SHIFT) && last_q && i_shift_en));
  assign accept_s = i_vld && o_rdy;

  // Next-state computation; abort overrides everything else.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    loop_d  = loop_q;
    if (i_abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      loop_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            state_d = S_SHIFT;
            word_d  = i_data;
            loop_d  = i_loop;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SHIFT: begin
          if (i_shift_en) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d = '0;
              if (accept_s) begin
                word_d = i_data;
                loop_d = i_loop;
              end else if (loop_q) begin
                state_d = S_SHIFT;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          loop_d  = 1'b0;
        end
      endcase
    end

    busy_d    = (state_d == S_SHIFT);
    out_vld_d = busy_d;
    out_d     = busy_d ? bit_at(word_d, cnt_d) : IDLE_LEVEL;
    last_d    = busy_d && (cnt_d == CNT_LAST);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      cnt_q     <= '0;
      loop_q    <= 1'b0;
      out_q     <= IDLE_LEVEL;
      out_vld_q <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      loop_q    <= loop_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
    end
  end

  assign o_out     = out_q;
  assign o_out_vld = out_vld_q;
  assign o_last    = last_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_shiftreg_ser.sv
// Bench for shiftreg_ser: two instances (MSB-first/idle 0 and LSB-first/idle 1) share stimulus and
// are compared every cycle against a bit-queue reference model.
module tb_shiftreg_ser;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       vld, lp, sh, ab;
  logic       rdy_a, out_a, ovld_a, last_a, busy_a;
  logic       rdy_b, out_b, ovld_b, last_b, busy_b;

  int total = 0;
  int bad   = 0;
  int vld_cnt;

  logic       q_a[$];
  logic       q_b[$];
  logic [7:0] word_m;
  logic       loop_m;

  shiftreg_ser #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .i_data(data), .i_vld(vld), .o_rdy(rdy_a), .i_loop(lp),
    .i_shift_en(sh), .i_abort(ab), .o_out(out_a), .o_out_vld(ovld_a), .o_last(last_a),
    .o_busy(busy_a));

  shiftreg_ser #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .i_data(data), .i_vld(vld), .o_rdy(rdy_b), .i_loop(lp),
    .i_shift_en(sh), .i_abort(ab), .o_out(out_b), .o_out_vld(ovld_b), .o_last(last_b),
    .o_busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_m(input logic [7:0] w, input logic l);
    word_m = w;
    loop_m = l;
    q_a.delete();
    q_b.delete();
    for (int k = 0; k < 8; k++) begin
      q_a.push_back(w[7-k]);
      q_b.push_back(w[k]);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic s,
                     input logic a, input logic r);
    logic busy_m, rdy_m, acc;
    @(negedge clk);
    vld = v; data = d; lp = l; sh = s; ab = a; rst = r;
    #1;
    if (r) begin
      q_a.delete();
      q_b.delete();
      loop_m = 1'b0;
    end
    busy_m = (q_a.size() != 0);
    rdy_m  = !r && !a && (!busy_m || (q_a.size() == 1 && s));

    check("a_out",  out_a,  busy_m ? q_a[0] : 1'b0);
    check("a_vld",  ovld_a, busy_m);
    check("a_last", last_a, q_a.size() == 1);
    check("a_busy", busy_a, busy_m);
    check("a_rdy",  rdy_a,  rdy_m);
    check("b_out",  out_b,  busy_m ? q_b[0] : 1'b1);
    check("b_vld",  ovld_b, busy_m);
    check("b_last", last_b, q_b.size() == 1);
    check("b_busy", busy_b, busy_m);
    check("b_rdy",  rdy_b,  rdy_m);
    vld_cnt += int'(ovld_a);

    if (!r) begin
      if (a) begin
        q_a.delete();
        q_b.delete();
        loop_m = 1'b0;
      end else begin
        acc = v && rdy_m;
        if (!busy_m) begin
          if (acc) load_m(d, l);
        end else if (s) begin
          if (q_a.size() == 1) begin
            if (acc) load_m(d, l);
            else if (loop_m) load_m(word_m, loop_m);
            else begin
              q_a.delete();
              q_b.delete();
            end
          end else begin
            void'(q_a.pop_front());
            void'(q_b.pop_front());
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; data = 8'h00; lp = 1'b0; sh = 1'b0; ab = 1'b0;
    loop_m = 1'b0; word_m = 8'h00;

    repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Single word, continuous shifting (both bit orders via the two instances).
    vld_cnt = 0;
    cyc(1'b1, 8'hE3, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (11) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("single_vld_cycles", vld_cnt, 8);

    // Back-to-back words with i_vld held.
    vld_cnt = 0;
    cyc(1'b1, 8'hE3, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (8) cyc(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (12) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("b2b_vld_cycles", vld_cnt, 16);

    // Shift tick every third cycle.
    vld_cnt = 0;
    cyc(1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) cyc(1'b0, 8'h00, 1'b0, (i % 3) == 2, 1'b0, 1'b0);
    check("slow_vld_cycles", vld_cnt, 24);

    // Loop mode with changing i_data/i_loop, then abort.
    cyc(1'b1, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (20) cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                    1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a word, then a fresh word.
    cyc(1'b1, 8'hE3, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)),
          8'($urandom),
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 39) == 0,
          $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
